tx_frame_scheduler: RTL
=======================

# tx_frame_scheduler

Round-robin frame scheduler sitting in front of `serial_transmitter`. It arbitrates among `NUM_REQ` parallel-word requesters, latches the winning word, and sequences it bit by bit onto the 1-bit `data_in` of the serializer as a framed stream: start, data LSB first, optional parity, stop, then an inter-frame gap. It transmits one bit per `clk` cycle and owns the transmitter line exclusively.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: payload width in bits, 1..32.
- `GAP_BITS`, 2: idle (`1`) bits after the stop bit, 1..15.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `reset_n` input 1: reset is synchronous and active-low.
- `req` input NUM_REQ: per-requester request level.
- `req_data` input NUM_REQ*DATA_W: word for requester i at bits [i*DATA_W +: DATA_W].
- `grant` output NUM_REQ: one-hot, single-cycle pulse when requester i's word is latched.
- `cur_id` output clog2(NUM_REQ): index of the requester whose frame is on the line.
- `tx_busy` output 1: high while a frame (start through last gap bit) is being sent.
- `tx_data` output 1: bit stream to `serial_transmitter.data_in`; idle level `1`.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, GAP.
- Arbitration point: any cycle in IDLE, or the last GAP cycle. If `req` is nonzero, the winner is the first set bit at or after `rr_ptr`, searching upward with wrap. On the next edge:
  - the winner's word is latched;
  - `grant[winner]` = 1 for exactly one cycle;
  - `cur_id` = winner;
  - `rr_ptr` = (winner+1) mod NUM_REQ;
  - state goes to START.
- No request at an arbitration point: IDLE, or GAP→IDLE.
- START: `tx_data`=0 for 1 cycle → DATA.
- DATA: `tx_data` = latched word bit k, k = 0..DATA_W-1, one per cycle. Bit counter is width clog2(DATA_W+1). After bit DATA_W-1, go to PARITY (if compiled in) or STOP.
- PARITY: `tx_data` = XOR of all DATA_W latched bits (even parity), 1 cycle → STOP.
- STOP: `tx_data`=1, 1 cycle → GAP.
- GAP: `tx_data`=1 for GAP_BITS cycles. The last one is an arbitration point.
- `tx_busy`=1 in START, DATA, PARITY, STOP and GAP; 0 in IDLE.
- `req` is ignored in every cycle that is not an arbitration point. The latched word is immune to `req_data` changes after the latch edge.
- Requester contract: hold `req` and `req_data` stable until `grant` is seen. Deassert `req` in the `grant` cycle, or keep it high to queue another frame.
- A requester dropping `req` before being granted loses its request silently. No partial frame is ever sent.

## Timing
- Reset (edge with `reset_n`=0):
  - `tx_data`=1, `tx_busy`=0, `grant`=0, `cur_id`=0;
  - `rr_ptr`=0, state IDLE.
  - Reset wins over every other event. A frame in progress is truncated and the line returns to `1` on the next cycle. No grant is issued during reset.
- Latency: request seen in IDLE at edge N → `grant` and START (`tx_data`=0) both visible after edge N+1.
- Frame length L = 2 + DATA_W + P + GAP_BITS cycles, where P = 1 with parity and 0 without. L = 12 with defaults and no parity.
- Back-to-back: with continuous requests, the START of frame n+1 immediately follows the last GAP cycle of frame n. There is no IDLE cycle, and throughput is one frame per L cycles.
- Simultaneous requests are resolved purely by `rr_ptr`. Any requester waits at most NUM_REQ-1 frames.
- `rr_ptr` wraps from NUM_REQ-1 to 0.

## Configuration
- `TX_SCHED_PARITY_EN`
  - Defined: the PARITY state is present, and one even-parity bit is inserted between DATA and STOP.
  - Undefined: the PARITY state and its XOR logic are removed, and DATA goes directly to STOP.

## Test plan
- Single requester (defaults, no parity): req[0]=1, data 0xA5.
  - `grant`=4'b0001 for 1 cycle.
  - `tx_data` = 0, 1,0,1,0,0,1,0,1, 1, 1,1.
  - `tx_busy` high for 12 cycles, then IDLE.
- Requests 4'b1010 raised together from reset: grant order 1, 3, 1, 3 while both remain held. `cur_id` tracks each grant.
- All four requesters held high: grants rotate 0,1,2,3,0. Consecutive STARTs are exactly 12 cycles apart with no IDLE cycle.
- Parity build (macro defined): data 0x07 gives parity bit 1, and data 0x03 gives 0. Frame length is 13.
- `reset_n`=0 during DATA bit 3: next cycle `tx_data`=1, `tx_busy`=0, `cur_id`=0. After release, the first grant goes to the lowest pending index (`rr_ptr`=0).
- `req_data` changed on the cycle after `grant`: the transmitted bits still match the word latched at grant.

Source files
------------

// File: rtl/tx_frame_scheduler.sv
// Round-robin frame scheduler feeding a 1-bit serializer: start, LSB-first data,
// optional even parity (TX_SCHED_PARITY_EN), stop, then GAP_BITS idle bits.
module tx_frame_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [$clog2(NUM_REQ)-1:0]  cur_id,
  output logic                        tx_busy,
  output logic                        tx_data
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_SCHED_PARITY_EN
    PARITY,
`endif
    STOP,
    GAP
  } state_t;

  state_t              state, state_n;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_n;
  logic [ID_W-1:0]     cur_id_q, cur_id_n;
  logic [NUM_REQ-1:0]  grant_q, grant_n;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
`ifdef TX_SCHED_PARITY_EN
  logic                parity_q, parity_n;
`endif

  logic                arb_en;
  logic                found;
  logic [ID_W-1:0]     winner;

  // Round-robin search: first set req bit at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  // Handshake: a requester holds req and req_data until grant pulses; the word
  // is captured on that same edge, so later req_data changes never reach the line.
  always_comb begin
    state_n   = state;
    rr_ptr_n  = rr_ptr;
    cur_id_n  = cur_id_q;
    grant_n   = '0;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    shreg_n   = shreg;
`ifdef TX_SCHED_PARITY_EN
    parity_n  = parity_q;
`endif
    arb_en    = 1'b0;
    tx_data   = 1'b1;
    tx_busy   = 1'b1;

    case (state)
      IDLE: begin
        tx_busy = 1'b0;
        arb_en  = 1'b1;
      end
      START: begin
        tx_data   = 1'b0;
        bit_cnt_n = '0;
        state_n   = DATA;
      end
      DATA: begin
        tx_data   = shreg[0];
        shreg_n   = shreg >> 1;
        bit_cnt_n = bit_cnt + 1'b1;
        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef TX_SCHED_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef TX_SCHED_PARITY_EN
      PARITY: begin
        tx_data = parity_q;
        state_n = STOP;
      end
`endif
      STOP: begin
        gap_cnt_n = '0;
        state_n   = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_BITS - 1)) begin
          arb_en  = 1'b1;
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Last gap cycle doubles as an arbitration point, giving back-to-back frames.
    if (arb_en && found) begin
      state_n         = START;
      shreg_n         = req_data[int'(winner)*DATA_W +: DATA_W];
      grant_n[winner] = 1'b1;
      cur_id_n        = winner;
      rr_ptr_n        = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      bit_cnt_n       = '0;
`ifdef TX_SCHED_PARITY_EN
      parity_n        = ^req_data[int'(winner)*DATA_W +: DATA_W];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cur_id_q <= '0;
      grant_q  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
`ifdef TX_SCHED_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      cur_id_q <= cur_id_n;
      grant_q  <= grant_n;
      bit_cnt  <= bit_cnt_n;
      gap_cnt  <= gap_cnt_n;
      shreg    <= shreg_n;
`ifdef TX_SCHED_PARITY_EN
      parity_q <= parity_n;
`endif
    end
  end

  assign grant  = grant_q;
  assign cur_id = cur_id_q;

endmodule
